mc_control_fsm: RTL
===================

Name: mc_control_fsm

Overview:
- Next-generation control unit for the multicycle RISC-V core.
- The state register is internal, and the block drives all datapath strobes as Moore outputs of that state.
- Fetch and data-memory states wait on a mem_ready handshake, so memory may take a variable number of cycles.
- A parametrised watchdog and sticky halt/fault reporting let the testbench stop cleanly.

Parameters:
- OPCODE_W, 7: opcode field width.
- STATE_W, 4: state register width. Must be ≥4.
- MEM_TIMEOUT, 16: maximum consecutive wait cycles with mem_ready low before FAULT. 0 disables the watchdog.
- CNT_W, 32: width of the performance counters.

Ports:
- clk, in, 1: rising-edge clock.
- reset_n, in, 1: asynchronous, active-low reset.
- opcode, in, OPCODE_W: IR[6:0].
- bcond, in, 1: branch-compare result from the ALU, valid in BR.
- mem_ready, in, 1: memory completes the current read/write this cycle.
- pc_write, out, 1: PC write enable.
- pc_source, out, 2: next-PC select. 00 = PC+4 (latched by the datapath in ID), 01 = ALU result, 10 = ALUOut.
- i_or_d, out, 1: memory address select. 0 = PC, 1 = ALUOut.
- mem_read, out, 1: memory read strobe.
- mem_write, out, 1: memory write strobe.
- ir_write, out, 1: IR and PC+4 latch enable.
- mem_to_reg, out, 2: write-back select. 00 = ALUOut, 01 = MDR, 10 = PC+4.
- reg_write, out, 1: register file write enable.
- alu_src_a, out, 1: ALU A select. 0 = PC, 1 = rs1.
- alu_src_b, out, 2: ALU B select. 00 = rs2, 01 = 4, 10 = imm.
- alu_op, out, 2: ALU op class. 00 = add, 01 = compare, 10 = funct-decoded.
- is_halted, out, 1: sticky; core stopped.
- is_fault, out, 1: sticky; illegal opcode or memory timeout.
- state, out, STATE_W: current state, for debug.
- cycle_cnt, out, CNT_W: see Optional Feature.
- instret_cnt, out, CNT_W: see Optional Feature.

Behaviour:
- Reset (asynchronous, while reset_n=0): state=IF(0); watchdog counter=0; all outputs 0 except the IF strobes (mem_read=1).
- Outputs are decoded from the registered state. Strobes not listed for a state are 0.
  - IF(0): mem_read=1; ir_write=mem_ready. Go to ID when mem_ready=1, else stay.
  - ID(1): alu_src_b=01.
    - Decode: 0110011→EX_R; 0010011→EX_I; 0000011/0100011→EX_ADDR; 1100011→BR; 1101111→JAL; 1100111→JALR; 1110011→HALT; anything else→FAULT.
  - EX_R(2): alu_src_a=1, alu_op=10. Go to WB_ALU.
  - EX_I(3): alu_src_a=1, alu_src_b=10, alu_op=10. Go to WB_ALU.
  - WB_ALU(4): reg_write=1, pc_write=1, pc_source=00. Go to IF.
  - EX_ADDR(5): alu_src_a=1, alu_src_b=10. Go to MEM_LD if opcode=LOAD, else MEM_ST.
  - MEM_LD(6): i_or_d=1, mem_read=1. Go to WB_LD on mem_ready.
  - WB_LD(7): reg_write=1, mem_to_reg=01, pc_write=1. Go to IF.
  - MEM_ST(8): i_or_d=1, mem_write=1; pc_write=mem_ready. Go to IF on mem_ready.
  - BR(9): alu_src_a=1, alu_op=01.
    - bcond=1: go to BR_TAKE.
    - bcond=0: pc_write=1, pc_source=00, go to IF.
  - BR_TAKE(10): alu_src_b=10, pc_write=1, pc_source=01. Go to IF.
  - JAL(11): alu_src_b=10, reg_write=1, mem_to_reg=10, pc_write=1, pc_source=01. Go to IF.
  - JALR(12): same as JAL but alu_src_a=1 (the datapath clears target bit 0).
  - HALT(13): all strobes 0; is_halted=1. Stays in HALT until reset.
  - FAULT(14): all strobes 0; is_fault=1 and is_halted=1. Stays until reset.
  - Encoding 15 (unreachable): next state is FAULT.
- Watchdog:
  - Increments each cycle in IF, MEM_LD or MEM_ST while mem_ready=0; clears on any state change.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0, the next state is FAULT.
  - mem_ready=1 in that same cycle wins: no fault.
- Latency (zero-wait memory): R/I-type 4 cycles; load 5; store 4; branch 3 not-taken / 4 taken; JAL/JALR 3.
- Reset mid-instruction: the FSM aborts immediately to IF; sticky flags clear.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every cycle outside HALT/FAULT.
  - instret_cnt increments on each transition into IF from a non-IF state.
  - Both counters wrap modulo 2^CNT_W and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- R-type 0110011, mem_ready=1 always → states 0,1,2,4,0; reg_write=1 and pc_write=1 only in cycle 4.
- Load 0000011, mem_ready held low 3 cycles in MEM_LD → 3 stall cycles in state 6, then WB_LD with mem_to_reg=01; 8 cycles total.
- Branch 1100011 with bcond=0, then bcond=1 → 3-cycle path with pc_source=00; 4-cycle path ending BR_TAKE with pc_source=01.
- Opcode 1110011 → HALT after ID; is_halted=1 stays high for 100 cycles; no strobes asserted.
- Opcode 0000000 → FAULT; is_fault=1. Separately, MEM_TIMEOUT=16 with mem_ready=0 in IF → FAULT on cycle 17. reset_n=0 mid-run → state=0 asynchronously.
- With MC_PERF_CNT_EN defined, 10 back-to-back R-type instructions → instret_cnt=10, cycle_cnt=40.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V control FSM: Moore strobe decode, mem_ready handshakes, watchdog, sticky halt/fault.
// Optional performance counters are enabled with `define MC_PERF_CNT_EN.
module mc_control_fsm #(
  parameter int OPCODE_W    = 7,
  parameter int STATE_W     = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                bcond,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic [1:0]          pc_source,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic [1:0]          mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                is_halted,
  output logic                is_fault,
  output logic [STATE_W-1:0]  state,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instret_cnt
);

  typedef enum logic [STATE_W-1:0] {
    S_IF      = STATE_W'(0),
    S_ID      = STATE_W'(1),
    S_EX_R    = STATE_W'(2),
    S_EX_I    = STATE_W'(3),
    S_WB_ALU  = STATE_W'(4),
    S_EX_ADDR = STATE_W'(5),
    S_MEM_LD  = STATE_W'(6),
    S_WB_LD   = STATE_W'(7),
    S_MEM_ST  = STATE_W'(8),
    S_BR      = STATE_W'(9),
    S_BR_TAKE = STATE_W'(10),
    S_JAL     = STATE_W'(11),
    S_JALR    = STATE_W'(12),
    S_HALT    = STATE_W'(13),
    S_FAULT   = STATE_W'(14)
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_I    = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_BR   = OPCODE_W'(7'b1100011);
  localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(7'b1101111);
  localparam logic [OPCODE_W-1:0] OP_JALR = OPCODE_W'(7'b1100111);
  localparam logic [OPCODE_W-1:0] OP_SYS  = OPCODE_W'(7'b1110011);

  localparam int             WD_W      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic           WD_ENABLE = (MEM_TIMEOUT > 0);
  localparam logic [WD_W-1:0] WD_LAST  = (MEM_TIMEOUT > 0) ? WD_W'(MEM_TIMEOUT - 1) : {WD_W{1'b0}};

  state_t          state_r;
  state_t          fsm_next_s;
  state_t          state_next_s;
  logic [WD_W-1:0] wd_r;
  logic            wait_state_s;
  logic            mem_stall_s;
  logic            wd_expire_s;

  // Watchdog qualifiers: memory-wait states stalled on mem_ready
  always_comb begin
    wait_state_s = (state_r == S_IF) || (state_r == S_MEM_LD) || (state_r == S_MEM_ST);
    mem_stall_s  = wait_state_s && !mem_ready;
    wd_expire_s  = WD_ENABLE && mem_stall_s && (wd_r == WD_LAST);
  end

  // Next-state sequencing; the watchdog overrides any stalled transition
  always_comb begin
    fsm_next_s = state_r;
    case (state_r)
      S_IF: begin
        if (mem_ready) fsm_next_s = S_ID;
        else           fsm_next_s = S_IF;
      end
      S_ID: begin
        case (opcode)
          OP_R:         fsm_next_s = S_EX_R;
          OP_I:         fsm_next_s = S_EX_I;
          OP_LD, OP_ST: fsm_next_s = S_EX_ADDR;
          OP_BR:        fsm_next_s = S_BR;
          OP_JAL:       fsm_next_s = S_JAL;
          OP_JALR:      fsm_next_s = S_JALR;
          OP_SYS:       fsm_next_s = S_HALT;
          default:      fsm_next_s = S_FAULT;
        endcase
      end
      S_EX_R:   fsm_next_s = S_WB_ALU;
      S_EX_I:   fsm_next_s = S_WB_ALU;
      S_WB_ALU: fsm_next_s = S_IF;
      S_EX_ADDR: begin
        if (opcode == OP_LD) fsm_next_s = S_MEM_LD;
        else                 fsm_next_s = S_MEM_ST;
      end
      S_MEM_LD: begin
        if (mem_ready) fsm_next_s = S_WB_LD;
        else           fsm_next_s = S_MEM_LD;
      end
      S_WB_LD:  fsm_next_s = S_IF;
      S_MEM_ST: begin
        if (mem_ready) fsm_next_s = S_IF;
        else           fsm_next_s = S_MEM_ST;
      end
      S_BR: begin
        if (bcond) fsm_next_s = S_BR_TAKE;
        else       fsm_next_s = S_IF;
      end
      S_BR_TAKE: fsm_next_s = S_IF;
      S_JAL:     fsm_next_s = S_IF;
      S_JALR:    fsm_next_s = S_IF;
      S_HALT:    fsm_next_s = S_HALT;
      S_FAULT:   fsm_next_s = S_FAULT;
      default:   fsm_next_s = S_FAULT;
    endcase
    state_next_s = wd_expire_s ? S_FAULT : fsm_next_s;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= S_IF;
    else          state_r <= state_next_s;
  end

  // Consecutive-stall counter, cleared whenever the state moves
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       wd_r <= {WD_W{1'b0}};
    else if (state_next_s != state_r)   wd_r <= {WD_W{1'b0}};
    else if (WD_ENABLE && mem_stall_s)  wd_r <= wd_r + WD_W'(1);
    else                                wd_r <= wd_r;
  end

  // Datapath strobes decoded from the registered state
  always_comb begin
    pc_write   = 1'b0;
    pc_source  = 2'b00;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 2'b00;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    is_halted  = 1'b0;
    is_fault   = 1'b0;
    case (state_r)
      S_IF: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
      end
      S_ID: alu_src_b = 2'b01;
      S_EX_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_EX_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b10;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
      end
      S_EX_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_LD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      S_WB_LD: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        pc_write   = 1'b1;
      end
      S_MEM_ST: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        pc_write  = mem_ready;
      end
      S_BR: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_write  = !bcond;
      end
      S_BR_TAKE: begin
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        pc_source = 2'b01;
      end
      S_JAL, S_JALR: begin
        alu_src_a  = (state_r == S_JALR);
        alu_src_b  = 2'b10;
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
        pc_write   = 1'b1;
        pc_source  = 2'b01;
      end
      S_HALT: is_halted = 1'b1;
      S_FAULT: begin
        is_halted = 1'b1;
        is_fault  = 1'b1;
      end
      default: begin
        is_halted = 1'b0;
        is_fault  = 1'b0;
      end
    endcase
  end

  assign state = state_r;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_r;
  logic [CNT_W-1:0] instret_cnt_r;

  // Cycle counter runs while the core is live; a retire is any return to IF
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt_r   <= {CNT_W{1'b0}};
      instret_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if ((state_r != S_HALT) && (state_r != S_FAULT)) cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
      else                                             cycle_cnt_r <= cycle_cnt_r;
      if ((state_next_s == S_IF) && (state_r != S_IF)) instret_cnt_r <= instret_cnt_r + CNT_W'(1);
      else                                             instret_cnt_r <= instret_cnt_r;
    end
  end

  assign cycle_cnt   = cycle_cnt_r;
  assign instret_cnt = instret_cnt_r;
`else
  assign cycle_cnt   = {CNT_W{1'b0}};
  assign instret_cnt = {CNT_W{1'b0}};
`endif

endmodule
